// File: rtl/smm_pair_scheduler.sv
// Pair scheduler for the sparse matrix multiplier: records A-row / B-column occupancy,
// issues only (row,col) pairs where both are occupied, and tags returned MAC results.
module smm_pair_scheduler #(
  parameter int N      = 32,
  parameter int IDXW   = 5,
  parameter int VALW   = 9,
  parameter int MAXINF = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            a_nz_valid,
  input  logic [IDXW-1:0] a_nz_row,
  input  logic            b_nz_valid,
  input  logic [IDXW-1:0] b_nz_col,
  input  logic            load_done,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic [IDXW-1:0] cmd_row,
  output logic [IDXW-1:0] cmd_col,
  input  logic            res_valid,
  input  logic [VALW-1:0] res_val,
  output logic            out_valid,
  output logic [IDXW-1:0] out_row,
  output logic [IDXW-1:0] out_col,
  output logic [VALW-1:0] out_val,
  output logic            busy,
  output logic            done
);

  localparam int PW = $clog2(MAXINF);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAXINF);
  localparam logic [IDXW-1:0] LAST    = IDXW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [N-1:0]      arow_map, bcol_map;
  logic [IDXW-1:0]   r, c, r_nx, c_nx;
  logic [2*IDXW-1:0] tag_mem [MAXINF];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              offer, advance, row_skip, issue_end;
  logic              xfer, pop;
  logic [2*IDXW-1:0] head_tag;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    r_nx      = r;
    c_nx      = c;
    offer     = 1'b0;
    advance   = 1'b0;
    row_skip  = 1'b0;
    issue_end = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD: begin
        if (load_done) begin
          state_nx = S_ISSUE;
          r_nx     = '0;
          c_nx     = '0;
        end
      end
      S_ISSUE: begin
        if (!arow_map[r]) begin
          row_skip = 1'b1;
          advance  = 1'b1;
        end else if (!bcol_map[c]) begin
          advance = 1'b1;
        end else begin
          offer   = (count < MAX_CNT);
          advance = offer && cmd_ready;
        end
        if (advance) begin
          if (row_skip || c == LAST) begin
            r_nx      = r + IDXW'(1);
            c_nx      = '0;
            issue_end = (r == LAST);
          end else begin
            c_nx = c + IDXW'(1);
          end
        end
        if (issue_end) state_nx = S_DRAIN;
      end
      S_DRAIN: if (count == '0) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign xfer      = offer && cmd_ready;
  assign pop       = res_valid && (count != '0);
  assign head_tag  = tag_mem[rd_ptr];
  assign cmd_valid = offer;
  assign cmd_row   = offer ? r : '0;
  assign cmd_col   = offer ? c : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= S_IDLE;
      r         <= '0;
      c         <= '0;
      arow_map  <= '0;
      bcol_map  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_val   <= '0;
    end else begin
      state <= state_nx;
      r     <= r_nx;
      c     <= c_nx;
      if (state == S_IDLE && start) begin
        arow_map <= '0;
        bcol_map <= '0;
      end else if (state == S_LOAD) begin
        if (a_nz_valid) arow_map[a_nz_row] <= 1'b1;
        if (b_nz_valid) bcol_map[b_nz_col] <= 1'b1;
      end
      if (xfer) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({xfer, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Zero results are dropped; out_* fields read as zero whenever out_valid is low.
      if (pop && res_val != '0) begin
        out_valid <= 1'b1;
        out_row   <= head_tag[2*IDXW-1:IDXW];
        out_col   <= head_tag[IDXW-1:0];
        out_val   <= res_val;
      end else begin
        out_valid <= 1'b0;
        out_row   <= '0;
        out_col   <= '0;
        out_val   <= '0;
      end
    end
  end

  // NOTE: tag storage needs no reset; count and pointers guarantee no entry is read before it is written.
  always_ff @(posedge clk) begin
    if (xfer) tag_mem[wr_ptr] <= {r, c};
  end

endmodule

// File: tb/tb_smm_pair_scheduler.sv
// Directed bench for smm_pair_scheduler: a latency-configurable MAC model answers
// commands, a negedge monitor logs traffic, and expectations are hand-computed.
module tb_smm_pair_scheduler;

  localparam int N    = 32;
  localparam int IDXW = 5;
  localparam int VALW = 9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic            a_nz_valid = 1'b0;
  logic [IDXW-1:0] a_nz_row = '0;
  logic            b_nz_valid = 1'b0;
  logic [IDXW-1:0] b_nz_col = '0;
  logic            load_done = 1'b0;
  logic            cmd_valid;
  logic            cmd_ready = 1'b0;
  logic [IDXW-1:0] cmd_row, cmd_col;
  logic            res_valid = 1'b0;
  logic [VALW-1:0] res_val = '0;
  logic            out_valid;
  logic [IDXW-1:0] out_row, out_col;
  logic [VALW-1:0] out_val;
  logic            busy, done;

  smm_pair_scheduler #(.N(N), .IDXW(IDXW), .VALW(VALW), .MAXINF(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_nz_valid(a_nz_valid), .a_nz_row(a_nz_row),
    .b_nz_valid(b_nz_valid), .b_nz_col(b_nz_col),
    .load_done(load_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .res_valid(res_valid), .res_val(res_val),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .out_val(out_val),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Traffic logs filled by the monitor
  int cmd_log[$];
  int out_r[$], out_c[$], out_v[$], out_cyc[$];
  int res_cyc[$];
  int pend[$];
  int vals[$];
  int done_cnt = 0, done_cyc = 0;
  int inflight = 0, max_inf = 0, zero_viol = 0;
  int stall_viol = 0, cmds_at_res = -1, cmdv_at_res = -1;
  bit res_seen = 0, t3_mode = 0, mac_en = 0;
  int mac_lat = 1;

  always @(negedge clk) begin
    if (t3_mode && !res_seen && cmd_valid && cmd_log.size() >= 4) stall_viol++;
    if (res_valid && !res_seen) begin
      res_seen    = 1;
      cmds_at_res = cmd_log.size();
      cmdv_at_res = int'(cmd_valid);
    end
    if (res_valid) res_cyc.push_back(cyc);
    if (cmd_valid && cmd_ready) begin
      cmd_log.push_back(int'(cmd_row) * 32 + int'(cmd_col));
      pend.push_back(cyc);
      inflight++;
    end
    if (res_valid && inflight > 0) inflight--;
    if (inflight > max_inf) max_inf = inflight;
    if (out_valid) begin
      out_r.push_back(int'(out_row));
      out_c.push_back(int'(out_col));
      out_v.push_back(int'(out_val));
      out_cyc.push_back(cyc);
    end else if (out_row != '0 || out_col != '0 || out_val != '0) begin
      zero_viol++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // MAC model: answers each command in order, mac_lat cycles after its transfer.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      res_valid = 1'b0;
      res_val   = '0;
      if (mac_en && pend.size() > 0 && cyc >= pend[0] + mac_lat) begin
        void'(pend.pop_front());
        res_valid = 1'b1;
        res_val   = (vals.size() > 0) ? VALW'(vals.pop_front()) : VALW'(1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    cmd_log.delete(); out_r.delete(); out_c.delete(); out_v.delete(); out_cyc.delete();
    res_cyc.delete(); pend.delete(); vals.delete();
    inflight = 0; max_inf = 0; res_seen = 0; stall_viol = 0;
    cmds_at_res = -1; cmdv_at_res = -1; done_cnt = 0; done_cyc = 0;
  endtask

  task automatic run_load(input logic [31:0] am, input logic [31:0] bm, output int ld);
    ld = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_nz_valid = am[i];
      a_nz_row   = IDXW'(i);
      b_nz_valid = bm[i];
      b_nz_col   = IDXW'(i);
      load_done  = (i == N - 1);
      if (i == N - 1) ld = cyc;
      tick();
    end
    a_nz_valid = 1'b0;
    b_nz_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int base;
    bit seen;
    base = done_cnt;
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      tick();
      if (done_cnt > base) seen = 1;
    end
    if (!seen) check(tag, 0, 1);
    repeat (3) tick();
  endtask

  int ld;
  int base_out, base_done;

  initial begin
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_cmd_valid", int'(cmd_valid), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b0;
    tick();
    mac_en    = 1;
    cmd_ready = 1'b1;

    // 1: single pair (3,7), result 12 one cycle later
    clear_logs();
    mac_lat = 1;
    vals.push_back(12);
    run_load(32'h1 << 3, 32'h1 << 7, ld);
    wait_done("t1_done_timeout");
    check("t1_ncmd", cmd_log.size(), 1);
    check("t1_cmd", (cmd_log.size() > 0) ? cmd_log[0] : -1, 3 * 32 + 7);
    check("t1_nout", out_r.size(), 1);
    check("t1_out_row", (out_r.size() > 0) ? out_r[0] : -1, 3);
    check("t1_out_col", (out_c.size() > 0) ? out_c[0] : -1, 7);
    check("t1_out_val", (out_v.size() > 0) ? out_v[0] : -1, 12);
    check("t1_out_lat", (out_cyc.size() > 0 && res_cyc.size() > 0) ? out_cyc[0] - res_cyc[0] : -1, 1);
    check("t1_ndone", done_cnt, 1);

    // 2: corner rows/cols, row-major order
    clear_logs();
    run_load(32'h8000_0001, 32'h8000_0001, ld);
    wait_done("t2_done_timeout");
    check("t2_ncmd", cmd_log.size(), 4);
    check("t2_cmd0", (cmd_log.size() > 0) ? cmd_log[0] : -1, 0);
    check("t2_cmd1", (cmd_log.size() > 1) ? cmd_log[1] : -1, 31);
    check("t2_cmd2", (cmd_log.size() > 2) ? cmd_log[2] : -1, 31 * 32);
    check("t2_cmd3", (cmd_log.size() > 3) ? cmd_log[3] : -1, 31 * 32 + 31);
    check("t2_nout", out_r.size(), 4);

    // 3: slow MAC, in-flight limit of 4
    clear_logs();
    t3_mode = 1;
    mac_lat = 20;
    run_load(32'h1, 32'hFF, ld);
    wait_done("t3_done_timeout");
    t3_mode = 0;
    check("t3_cmds_before_res", cmds_at_res, 4);
    check("t3_cmdv_at_res", cmdv_at_res, 0);
    check("t3_stall_viol", stall_viol, 0);
    check("t3_max_inflight", max_inf, 4);
    check("t3_ncmd", cmd_log.size(), 8);
    check("t3_nout", out_r.size(), 8);

    // 4: zero results dropped
    clear_logs();
    mac_lat = 2;
    vals.push_back(0); vals.push_back(5); vals.push_back(0); vals.push_back(9);
    run_load(32'h6, 32'h30, ld);
    wait_done("t4_done_timeout");
    check("t4_ncmd", cmd_log.size(), 4);
    check("t4_nout", out_r.size(), 2);
    check("t4_out0_row", (out_r.size() > 0) ? out_r[0] : -1, 1);
    check("t4_out0_col", (out_c.size() > 0) ? out_c[0] : -1, 5);
    check("t4_out0_val", (out_v.size() > 0) ? out_v[0] : -1, 5);
    check("t4_out1_row", (out_r.size() > 1) ? out_r[1] : -1, 2);
    check("t4_out1_col", (out_c.size() > 1) ? out_c[1] : -1, 5);
    check("t4_out1_val", (out_v.size() > 1) ? out_v[1] : -1, 9);
    check("t4_done_after_out", (out_cyc.size() > 1) ? int'(done_cyc > out_cyc[1]) : 0, 1);

    // 5: reset with two commands in flight
    clear_logs();
    mac_lat = 30;
    run_load(32'h1, 32'h3, ld);
    for (int i = 0; i < 200 && cmd_log.size() < 2; i++) tick();
    check("t5_two_cmds", cmd_log.size(), 2);
    tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check("t5_busy", int'(busy), 0);
    check("t5_cmd_valid", int'(cmd_valid), 0);
    check("t5_out_valid", int'(out_valid), 0);
    check("t5_done", int'(done), 0);
    base_out  = out_r.size();
    base_done = done_cnt;
    repeat (50) tick();
    check("t5_late_results", res_cyc.size(), 2);
    check("t5_no_out", out_r.size() - base_out, 0);
    check("t5_no_done", done_cnt - base_done, 0);

    // 6: empty bitmaps, done N+2 cycles after load_done
    clear_logs();
    mac_lat = 1;
    run_load(32'h0, 32'h0, ld);
    wait_done("t6_done_timeout");
    check("t6_ncmd", cmd_log.size(), 0);
    check("t6_done_delay", done_cyc - ld, N + 2);
    check("t6_ndone", done_cnt, 1);

    check("out_zero_when_idle", zero_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 want 1");
    $fatal(1, "bench timeout");
  end

endmodule
